// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants for the timer_dev peripheral: register word offsets,
// CTRL bit positions, timer modes and FSM state encodings.
//
// Build option: TIMER_PRESCALE_EN widens the writable part of CTRL to
// include the PS field in bits [7:4].
// ---------------------------------------------------------------------------
package timer_pkg;

    // Word offsets inside the three-word register window
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL register layout
    localparam int CTRL_W       = 8;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PS_LO   = 4;
    localparam int CTRL_PS_HI   = 7;

    // MODE field values; 2 and 3 fall back to one-shot behaviour
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Bits of CTRL that software can actually store
`ifdef TIMER_PRESCALE_EN
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 8'hFF;
`else
    localparam logic [CTRL_W-1:0] CTRL_WMASK = 8'h0F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_bytewr.sv
// ---------------------------------------------------------------------------
// timer_bytewr
// Combinational byte-lane merge: lane i of new_val takes wd when mask[i] is
// set, otherwise keeps old_val. Lanes above the 4-bit mask always keep
// old_val.
//
// Ports:
//   old_val [W-1:0]  current register contents
//   wd      [W-1:0]  write data
//   mask    [3:0]    byte enables
//   new_val [W-1:0]  merged value
// ---------------------------------------------------------------------------
module timer_bytewr #(
    parameter int W = 32
) (
    input  logic [W-1:0] old_val,
    input  logic [W-1:0] wd,
    input  logic [3:0]   mask,
    output logic [W-1:0] new_val
);

    for (genvar i = 0; i < W / 8; i++) begin : g_lane
        if (i < 4) begin : g_masked
            assign new_val[8*i +: 8] = mask[i] ? wd[8*i +: 8] : old_val[8*i +: 8];
        end else begin : g_keep
            assign new_val[8*i +: 8] = old_val[8*i +: 8];
        end
    end

endmodule

// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev
// Programmable down-counter on the Bridge device side. Three-word register
// window (CTRL, PRESET, COUNT) addressed by word offset, one interrupt line.
//
// Ports:
//   Clk        system clock
//   Rst        synchronous active-high reset
//   DEV_Addr   word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   DEV_WD     write data
//   DEV_Mask   byte enables for writes
//   DEV_WE     write strobe (already qualified by the Bridge select)
//   DEV_RD     read data, combinational on DEV_Addr
//   IRQ        registered interrupt request (irq_flag & CTRL.IM)
//   dbg_state  current FSM state, for observation only
//
// Build option: TIMER_PRESCALE_EN adds the CTRL.PS field and a 4-bit
// prescaler that lets the counter act only once every PS+1 cycles.
//
// Bus handshake: there is no ready/valid pair; a write is accepted on every
// Clk edge where DEV_WE=1, and reads are always valid combinationally.
// ---------------------------------------------------------------------------
module timer_dev
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       DEV_Addr,
    input  logic [WIDTH-1:0] DEV_WD,
    input  logic [3:0]       DEV_Mask,
    input  logic             DEV_WE,
    output logic [WIDTH-1:0] DEV_RD,
    output logic             IRQ,
    output logic [1:0]       dbg_state
);

    timer_state_e      state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  preset_q, preset_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    logic              irq_q, irq_d;

    logic [CTRL_W-1:0] ctrl_wr_val;
    logic [WIDTH-1:0]  preset_wr_val;
    logic              wr_ctrl, wr_preset;
    logic              en;
    logic              reload_mode;
    logic              tick;

    assign wr_ctrl     = DEV_WE && (DEV_Addr == ADDR_CTRL);
    assign wr_preset   = DEV_WE && (DEV_Addr == ADDR_PRESET);
    assign en          = ctrl_q[CTRL_EN];
    assign reload_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    timer_bytewr #(.W(CTRL_W)) u_ctrl_wr (
        .old_val (ctrl_q),
        .wd      (DEV_WD[CTRL_W-1:0]),
        .mask    (DEV_Mask),
        .new_val (ctrl_wr_val)
    );

    timer_bytewr #(.W(WIDTH)) u_preset_wr (
        .old_val (preset_q),
        .wd      (DEV_WD),
        .mask    (DEV_Mask),
        .new_val (preset_wr_val)
    );

`ifdef TIMER_PRESCALE_EN
    logic [3:0] ps_cnt_q, ps_cnt_d;
    // The counter acts on the cycle where the prescaler reaches PS
    assign tick = (ps_cnt_q == ctrl_q[CTRL_PS_HI:CTRL_PS_LO]);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
`ifdef TIMER_PRESCALE_EN
        ps_cnt_d   = ps_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
`ifdef TIMER_PRESCALE_EN
                ps_cnt_d = '0;
`endif
            end
            ST_CNT: begin
                if (!en) begin
                    // COUNT freezes; a later enable reloads from PRESET
                    state_d = ST_IDLE;
`ifdef TIMER_PRESCALE_EN
                    ps_cnt_d = '0;
`endif
                end else begin
`ifdef TIMER_PRESCALE_EN
                    ps_cnt_d = tick ? 4'd0 : ps_cnt_q + 4'd1;
`endif
                    if (tick) begin
                        if (count_q == '0) begin
                            irq_flag_d = 1'b1;
                            state_d    = ST_INT;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                end
            end
            ST_INT: begin
                if (reload_mode) begin
                    // Flag is high only for the single INT cycle
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
`ifdef TIMER_PRESCALE_EN
                    ps_cnt_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software writes are applied last so they override the hardware
        // EN clear and any same-cycle irq_flag set.
        if (wr_ctrl) begin
            ctrl_d     = ctrl_wr_val & CTRL_WMASK;
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = preset_wr_val;
            irq_flag_d = 1'b0;
        end

        irq_d = irq_flag_d & ctrl_d[CTRL_IM];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
`ifdef TIMER_PRESCALE_EN
            ps_cnt_q   <= ps_cnt_d;
`endif
        end
    end

    always_comb begin
        DEV_RD = '0;
        unique case (DEV_Addr)
            ADDR_CTRL:   DEV_RD[CTRL_W-1:0] = ctrl_q;
            ADDR_PRESET: DEV_RD = preset_q;
            ADDR_COUNT:  DEV_RD = count_q;
            default:     DEV_RD = '0;
        endcase
    end

    assign IRQ       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_dev.sv
// ---------------------------------------------------------------------------
// tb_timer_dev
// Self-checking bench for timer_dev: scenario tasks with inline checks
// against a behavioural model of the register/timer rules.
// ---------------------------------------------------------------------------
module tb_timer_dev;
    import timer_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  DEV_Addr = 2'd0;
    logic [31:0] DEV_WD = '0;
    logic [3:0]  DEV_Mask = 4'h0;
    logic        DEV_WE = 1'b0;
    logic [31:0] DEV_RD;
    logic        IRQ;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / DUT ----------------
    always #10 Clk = ~Clk;

    timer_dev #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .DEV_Addr  (DEV_Addr),
        .DEV_WD    (DEV_WD),
        .DEV_Mask  (DEV_Mask),
        .DEV_WE    (DEV_WE),
        .DEV_RD    (DEV_RD),
        .IRQ       (IRQ),
        .dbg_state (dbg_state)
    );

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] M_CTRL_MASK = 8'hFF;
`else
    localparam logic [7:0] M_CTRL_MASK = 8'h0F;
`endif
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_INT = 3;

    logic [7:0]  m_ctrl = '0;
    logic [31:0] m_preset = '0;
    logic [31:0] m_count = '0;
    logic        m_flag = 1'b0;
    logic        m_irq = 1'b0;
    int          m_ph = PH_IDLE;
    int          m_div = 0;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic we, input logic [1:0] a,
                              input logic [31:0] wd, input logic [3:0] m);
        logic [7:0]  n_ctrl;
        logic [31:0] n_preset, n_count;
        logic        n_flag;
        int          n_ph, n_div;
        bit          tick;
        if (rst) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0;
            m_irq = 1'b0; m_ph = PH_IDLE; m_div = 0;
            return;
        end
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
        n_flag = m_flag; n_ph = m_ph; n_div = m_div;
        case (m_ph)
            PH_IDLE: if (m_ctrl[0]) n_ph = PH_LOAD;
            PH_LOAD: begin n_count = m_preset; n_div = 0; n_ph = PH_RUN; end
            PH_RUN: begin
                if (!m_ctrl[0]) begin
                    n_ph = PH_IDLE; n_div = 0;
                end else begin
`ifdef TIMER_PRESCALE_EN
                    tick  = (m_div == int'(m_ctrl[7:4]));
                    n_div = tick ? 0 : m_div + 1;
`else
                    tick = 1'b1;
`endif
                    if (tick) begin
                        if (m_count == 0) begin n_flag = 1'b1; n_ph = PH_INT; end
                        else n_count = m_count - 1;
                    end
                end
            end
            default: begin
                if (m_ctrl[2:1] == 2'd1) begin n_flag = 1'b0; n_ph = PH_LOAD; end
                else begin n_ctrl[0] = 1'b0; n_ph = PH_IDLE; n_div = 0; end
            end
        endcase
        if (we && a == 2'd0) begin
            n_ctrl = (m[0] ? wd[7:0] : m_ctrl) & M_CTRL_MASK;
            n_flag = 1'b0;
        end
        if (we && a == 2'd1) begin
            n_preset = (m_preset & ~lane_bits(m)) | (wd & lane_bits(m));
            n_flag = 1'b0;
        end
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
        m_flag = n_flag; m_ph = n_ph; m_div = n_div;
        m_irq = n_flag & n_ctrl[3];
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic rst, input logic we, input logic [1:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
        @(negedge Clk);
        Rst = rst; DEV_WE = we; DEV_Addr = a; DEV_WD = wd; DEV_Mask = m;
        @(posedge Clk);
        model_edge(rst, we, a, wd, m);
        #1;
        DEV_WE = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'd0, 4'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cycle(1'b0, 1'b1, a, wd, 4'hF);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        DEV_Addr = a;
        #1;
        v = DEV_RD;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [31:0] v;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_vec++;
            if (v !== 32'd0) begin
                n_err++; $display("FAIL reset_rd[%0d]: got %h want 0", a, v);
            end
        end
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state);
        end
    endtask

    task automatic test_oneshot(input int n);
        logic [31:0] v;
        int rise = -1;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        wr(ADDR_PRESET, 32'(n));
        wr(ADDR_CTRL, 32'h9);
        for (int k = 1; k <= n + 6; k++) begin
            idle(1);
            rd(ADDR_COUNT, v);
            n_vec++;
            if (v !== m_count) begin
                n_err++; $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, v, m_count);
            end
            n_vec++;
            if (IRQ !== m_irq) begin
                n_err++; $display("FAIL oneshot_irq k=%0d: got %b want %b", k, IRQ, m_irq);
            end
            if (IRQ === 1'b1 && rise < 0) rise = k;
        end
        n_vec++;
        if (rise != n + 3) begin
            n_err++; $display("FAIL oneshot_latency N=%0d: rose at %0d want %0d", n, rise, n + 3);
        end
        rd(ADDR_CTRL, v);
        n_vec++;
        if (v !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl: got %h want 8", v); end
        n_vec++;
        if (IRQ !== 1'b1) begin n_err++; $display("FAIL oneshot_hold: got %b want 1", IRQ); end
        wr(ADDR_PRESET, 32'd5);
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL oneshot_clear: got %b want 0", IRQ); end
    endtask

    task automatic test_reload(input int n);
        logic [31:0] v;
        logic prev = 1'b0;
        int pulses = 0, exp_pulses = 0;
        int period = n + 3;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        wr(ADDR_PRESET, 32'(n));
        wr(ADDR_CTRL, 32'hB);
        for (int k = 1; k <= 4 * period + 1; k++) begin
            idle(1);
            if (k >= period && (k - period) % period == 0) exp_pulses++;
            rd(ADDR_COUNT, v);
            n_vec++;
            if (v !== m_count) begin
                n_err++; $display("FAIL reload_count k=%0d: got %0d want %0d", k, v, m_count);
            end
            n_vec++;
            if (IRQ !== m_irq || (prev && IRQ)) begin
                n_err++; $display("FAIL reload_irq k=%0d: got %b want %b", k, IRQ, m_irq);
            end
            if (IRQ === 1'b1) pulses++;
            prev = IRQ;
        end
        n_vec++;
        if (pulses != exp_pulses) begin
            n_err++; $display("FAIL reload_pulses: got %0d want %0d", pulses, exp_pulses);
        end
        wr(ADDR_CTRL, 32'h3);
        for (int k = 0; k < 3 * period; k++) begin
            idle(1);
            rd(ADDR_COUNT, v);
            n_vec++;
            if (v !== m_count || IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL reload_masked k=%0d: count %0d irq %b want %0d/0", k, v, IRQ, m_count);
            end
        end
    endtask

    task automatic test_bytemask;
        logic [31:0] a, b, v, exp;
        logic [3:0]  m;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        for (int it = 0; it < 5; it++) begin
            a = (it == 0) ? 32'h11223344 : $urandom;
            b = (it == 0) ? 32'hAABBCCDD : $urandom;
            m = (it == 0) ? 4'b0101 : 4'($urandom_range(0, 15));
            exp = (it == 0) ? 32'h11BB33DD : ((a & ~lane_bits(m)) | (b & lane_bits(m)));
            wr(ADDR_PRESET, a);
            cycle(1'b0, 1'b1, ADDR_PRESET, b, m);
            rd(ADDR_PRESET, v);
            n_vec++;
            if (v !== exp) begin
                n_err++; $display("FAIL bytemask it=%0d m=%b: got %h want %h", it, m, v, exp);
            end
        end
        wr(ADDR_COUNT, $urandom);
        rd(ADDR_COUNT, v);
        n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL count_wr_ignored: got %h want 0", v); end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v);
        n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL reserved_rd: got %h want 0", v); end
        wr(ADDR_CTRL, 32'hFFFF_FFFF);
        rd(ADDR_CTRL, v);
        n_vec++;
        if (v !== {24'd0, M_CTRL_MASK}) begin
            n_err++; $display("FAIL ctrl_wmask: got %h want %h", v, M_CTRL_MASK);
        end
    endtask

    task automatic test_pause;
        logic [31:0] v;
        bit found = 0;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h1);
        for (int k = 0; k < 30; k++) begin
            idle(1);
            rd(ADDR_COUNT, v);
            if (v === 32'd7) begin found = 1; break; end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL pause_wait: COUNT never read 7"); end
        wr(ADDR_CTRL, 32'h0);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            rd(ADDR_COUNT, v);
            n_vec++;
            if (v !== 32'd6 || IRQ !== 1'b0) begin
                n_err++; $display("FAIL pause_hold k=%0d: count %0d irq %b want 6/0", k, v, IRQ);
            end
        end
        wr(ADDR_CTRL, 32'h1);
        idle(1);
        rd(ADDR_COUNT, v);
        n_vec++;
        if (v !== 32'd6) begin n_err++; $display("FAIL pause_load_cycle: got %0d want 6", v); end
        idle(1);
        rd(ADDR_COUNT, v);
        n_vec++;
        if (v !== 32'd10) begin n_err++; $display("FAIL pause_reload: got %0d want 10", v); end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        idle(3);
        n_vec++;
        if (IRQ !== 1'b1) begin n_err++; $display("FAIL coll_int_irq: got %b want 1", IRQ); end
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_CTRL, v);
        n_vec++;
        if (v !== 32'h1) begin n_err++; $display("FAIL coll_ctrl: got %h want 1", v); end
        n_vec++;
        if (IRQ !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL coll_after: irq %b state %0d want 0/IDLE", IRQ, dbg_state);
        end
        for (int k = 0; k < 6; k++) begin
            idle(1);
            n_vec++;
            if (IRQ !== 1'b0) begin n_err++; $display("FAIL coll_irq_masked k=%0d: got %b want 0", k, IRQ); end
        end
        rd(ADDR_CTRL, v);
        n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL coll_restart: ctrl %h want 0", v); end
        // PRESET write on the edge where the flag would be set
        wr(ADDR_CTRL, 32'h9);
        idle(2);
        wr(ADDR_PRESET, 32'd0);
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL coll_flagset: got %b want 0", IRQ); end
        idle(1);
        n_vec++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL coll_flagset_next: got %b want 0", IRQ); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        bit found = 0;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        wr(ADDR_PRESET, 32'($urandom_range(3, 9)));
        wr(ADDR_CTRL, 32'h9);
        for (int k = 0; k < 20; k++) begin
            idle(1);
            rd(ADDR_COUNT, v);
            if (v === 32'd1) begin found = 1; break; end
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL rstmid_wait: COUNT never read 1"); end
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_vec++;
            if (v !== 32'd0) begin n_err++; $display("FAIL rstmid_rd[%0d]: got %h want 0", a, v); end
        end
        n_vec++;
        if (IRQ !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL rstmid_state: irq %b state %0d want 0/IDLE", IRQ, dbg_state);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] v, wd;
        logic [1:0]  a;
        cycle(1'b1, 1'b0, 2'd0, 32'd0, 4'h0);
        for (int k = 0; k < n; k++) begin
            a = 2'($urandom_range(0, 3));
            wd = (a == ADDR_CTRL) ? $urandom : 32'($urandom_range(0, 6));
            if ($urandom_range(0, 9) < 6) idle(1);
            else cycle(1'b0, 1'b1, a, wd, 4'($urandom_range(0, 15)));
            for (int r = 0; r < 4; r++) begin
                rd(2'(r), v);
                n_vec++;
                if (v !== model_rd(2'(r))) begin
                    n_err++; $display("FAIL rand_rd k=%0d off=%0d: got %h want %h", k, r, v, model_rd(2'(r)));
                end
            end
            n_vec++;
            if (IRQ !== m_irq) begin
                n_err++; $display("FAIL rand_irq k=%0d: got %b want %b", k, IRQ, m_irq);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_oneshot(5);
        test_oneshot($urandom_range(0, 8));
        test_reload(2);
        test_reload($urandom_range(0, 4));
        test_bytemask();
        test_pause();
        test_collision();
        test_reset_mid();
        test_back_to_back(300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
